if_prefetch: RTL

Instruction-fetch prefetch stage between the instruction RAM2Kx32 (IM) and the pipeline decode input. It drives the IM word address and OEN, absorbs the one-cycle IM read latency, and buffers fetched instructions with their PCs in a small FIFO. Decode consumes them over a valid/ready handshake. Taken branches/jumps redirect fetch and flush all buffered and in-flight words; `halt` freezes new fetches.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_fifo.sv | 68 ++++++
 rtl/if_prefetch.sv | 103 ++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
//   PC_W       : IM word-address width
//   INSTR_W    : instruction width
//   if_entry_t : buffered fetch result {instr, pc}
//   pc_inc     : next sequential word address, wrapping 2047 -> 0
package if_pkg;

  localparam int PC_W    = 11;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } if_entry_t;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of fetched instructions for the prefetch stage.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (clears storage too)
//   push, din      : write an entry (ignored when full)
//   pop            : retire the head entry (ignored when empty)
//   flush          : drop all entries; wins over push/pop
//   dout           : head entry (first-word fall-through)
//   count          : number of entries held, 0..DEPTH
//   full, empty    : occupancy flags
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  if_entry_t     din,
  input  logic          pop,
  input  logic          flush,
  output if_entry_t     dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  if_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch stage between the instruction RAM and decode.
// Issues sequential IM word addresses, absorbs the one-cycle IM read latency
// and buffers {instr, pc} in a FIFO consumed over a valid/ready handshake.
// A redirect flushes buffered and in-flight words and restarts fetch at the
// target; halt only stops new fetches.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   im_addr, im_oen     : IM word address and active-low output enable
//   im_q                : IM read data, valid the cycle after issue
//   redirect, redirect_pc : taken branch/jump and its target word address
//   halt                : suppress new fetches while high
//   ir, ir_pc, ir_valid : FIFO head instruction, its address, head valid
//   ir_ready            : decode accepts the head this cycle
module if_prefetch
  import if_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 11'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    im_addr,
  output logic               im_oen,
  input  logic [INSTR_W-1:0] im_q,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = DEPTH[CW:0];

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic            full;
  logic            empty;
  logic            issue;
  logic            push;
  logic            pop;
  if_entry_t       push_entry;
  if_entry_t       head;

  // Credit check counts the in-flight word as already occupying a slot, so
  // the response always finds room when it lands.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue = !halt && !redirect && (used < DEPTH_L);

  // inflight is the registered issue, so the enable is low exactly while
  // the issued word is presented on im_q.
  assign im_addr = fetch_pc;
  assign im_oen  = !inflight;

  // Fetch stage: address issue and in-flight tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= pc_inc(fetch_pc);
      end
    end
  end

  // Response stage: capture IM data into the buffer
  assign push             = inflight && !redirect && !full;
  assign pop              = !empty && ir_ready && !redirect;
  assign push_entry.instr = im_q;
  assign push_entry.pc    = inflight_pc;

  if_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (redirect),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign ir       = head.instr;
  assign ir_pc    = head.pc;
  assign ir_valid = !empty;

endmodule
